fsm_moore_tx: RTL and testbench
===============================

FSM_MOORE_TX -- requirements
Module: fsm_moore_tx

Interface
Parameters:
REQ-001 The block SHALL have parameter DEB_DIV, default 131072, giving the clk cycles per debounce sample tick (minimum 2).
REQ-002 The block SHALL have parameter BIT_DIV, default 8388608, giving the clk cycles per transmitted bit (minimum 2).

Ports:
REQ-003 clk  input  1  system clock, 50 MHz on board; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 boton  input  1  raw, bouncing start pushbutton.
REQ-006 pattern  input  4  sequence to transmit, MSB first; sampled only at start acceptance.
REQ-007 ledSecuencia  output  1  serial data output, registered.
REQ-008 ledPasos  output  4  one-hot step indicator, registered.
REQ-009 busy  output  1  high while a sequence is being transmitted.
REQ-010 done  output  1  high for the full DONE state.

Function
REQ-011 A free-running debounce counter SHALL count 0..DEB_DIV-1 and wrap; deb_tick SHALL be high for one cycle at the terminal count.
REQ-012 On each deb_tick: d1 <= boton and d2 <= d1; btn_db SHALL equal d1 & d2, registered.
REQ-013 start_edge SHALL be a registered one-cycle pulse when btn_db is 1 and its previous-cycle value is 0.
REQ-014 Moore FSM states SHALL be IDLE, B3, B2, B1, B0 and DONE; all outputs SHALL be decoded from the registered state only.
REQ-015 IDLE: ledSecuencia=0, ledPasos=0000, busy=0, done=0; on start_edge, pat_q <= pattern and the next state is B3.
REQ-016 Bn (n=3..0): ledSecuencia=pat_q[n], ledPasos bit n=1 (B3 gives 1000 ... B0 gives 0001), busy=1, done=0.
REQ-017 DONE: ledSecuencia=0, ledPasos=1111, busy=1, done=1; the next state is IDLE.
REQ-018 The bit counter SHALL be cleared to 0 in the cycle start_edge is accepted, then count 0..BIT_DIV-1; bit_tick fires at BIT_DIV-1.
REQ-019 The FSM SHALL advance B3->B2->B1->B0->DONE->IDLE only on bit_tick.
REQ-020 Each of B3, B2, B1, B0 and DONE SHALL last exactly BIT_DIV clk cycles.
REQ-021 Latency: start_edge in cycle N SHALL give state B3 (outputs valid) in cycle N+1.
REQ-022 A start_edge in any state other than IDLE SHALL be ignored, and pat_q SHALL be unchanged.
REQ-023 A pattern change after acceptance SHALL NOT affect the transmission in progress.
REQ-024 Holding boton high SHALL start exactly one transmission; a new start requires btn_db to go low and then high again.
REQ-025 pattern=0000 SHALL still run the full sequence with ledSecuencia=0 throughout.
REQ-026 Unused state encodings SHALL recover to IDLE on the next cycle with IDLE outputs.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL clear state to IDLE and set to 0: both counters, d1, d2, btn_db, the start_edge history, pat_q, ledSecuencia, ledPasos (0000), busy and done.
REQ-028 Reset asserted mid-transmission SHALL abort the sequence; outputs SHALL show IDLE values in the cycle after the sampling edge.
REQ-029 No start SHALL be accepted while rst_n=0.

Verification (DEB_DIV=4, BIT_DIV=8)
REQ-030 Reset, then hold boton=0 for 200 cycles -> ledSecuencia=0, ledPasos=0000, busy=0, done=0 throughout.
REQ-031 pattern=1011, press boton clean for 40 cycles -> ledSecuencia over B3..B0 reads 1,0,1,1 (8 cycles each); ledPasos reads 1000, 0100, 0010, 0001, 1111; done high for 8 cycles; then IDLE.
REQ-032 Bouncing press (boton toggles every cycle for 10 cycles, then stable high) -> exactly one transmission.
REQ-033 Second press during B2 with pattern changed to 0110 -> the second press is ignored and the remainder still reflects 1011.
REQ-034 rst_n=0 for 1 cycle during B1 -> IDLE outputs next cycle; a fresh press then gives a complete sequence starting with B3 lasting 8 cycles.
REQ-035 pattern=0000, then 1111, back-to-back presses after each IDLE -> ledSecuencia is 0000 and 1111 respectively, and busy spans 40 cycles each time.

Source files
------------

// File: rtl/fsm_moore_tx_if.sv
// Pin bundle between the pushbutton sequence transmitter and whatever drives it.
// The board-level names (boton, ledSecuencia, ledPasos) are kept as they are.
interface fsm_moore_tx_if;
    logic       boton;
    logic [3:0] pattern;
    logic       ledSecuencia;
    logic [3:0] ledPasos;
    logic       busy;
    logic       done;

    modport master (
        output boton, pattern,
        input  ledSecuencia, ledPasos, busy, done
    );

    modport slave (
        input  boton, pattern,
        output ledSecuencia, ledPasos, busy, done
    );
endinterface

// File: rtl/fsm_moore_tx.sv
// Debounced pushbutton starts a 4-bit MSB-first transmission on an LED.
// Each bit, and a trailing DONE step, is held for BIT_DIV clocks.
module fsm_moore_tx #(
    parameter int DEB_DIV = 131072,
    parameter int BIT_DIV = 8388608
) (
    input  logic           clk,
    input  logic           rst_n,
    fsm_moore_tx_if.slave  bus
);
    localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int BW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B3   = 3'd1,
        B2   = 3'd2,
        B1   = 3'd3,
        B0   = 3'd4,
        DONE = 3'd5
    } state_t;

    logic [DW-1:0] deb_cnt;
    logic          deb_tick;
    logic          d1, d2, btn_db, btn_db_prev, start_edge;
    logic [BW-1:0] bit_cnt;
    logic          bit_tick;
    state_t        state, state_nx;
    logic [3:0]    pat_q, pat_nx;
    logic          led_q, led_nx;
    logic [3:0]    pasos_q, pasos_nx;
    logic          busy_q, busy_nx;
    logic          done_q, done_nx;

    assign deb_tick = (deb_cnt == DW'(DEB_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt     <= '0;
            d1          <= 1'b0;
            d2          <= 1'b0;
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
            start_edge  <= 1'b0;
        end else begin
            deb_cnt <= deb_tick ? '0 : deb_cnt + 1'b1;
            if (deb_tick) begin
                d1 <= bus.boton;
                d2 <= d1;
            end
            btn_db      <= d1 & d2;
            btn_db_prev <= btn_db;
            start_edge  <= btn_db & ~btn_db_prev;
        end
    end

    // Counter idles at zero, so the first bit period starts cleanly on acceptance.
    assign bit_tick = (state != IDLE) && (bit_cnt == BW'(BIT_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (state == IDLE || bit_tick)
            bit_cnt <= '0;
        else
            bit_cnt <= bit_cnt + 1'b1;
    end

    always_comb begin
        state_nx = state;
        pat_nx   = pat_q;
        case (state)
            IDLE: if (start_edge) begin
                state_nx = B3;
                pat_nx   = bus.pattern;
            end
            B3:      if (bit_tick) state_nx = B2;
            B2:      if (bit_tick) state_nx = B1;
            B1:      if (bit_tick) state_nx = B0;
            B0:      if (bit_tick) state_nx = DONE;
            DONE:    if (bit_tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are a pure decode of the upcoming state, registered alongside it.
        led_nx   = 1'b0;
        pasos_nx = 4'b0000;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state_nx)
            B3:   begin led_nx = pat_nx[3]; pasos_nx = 4'b1000; busy_nx = 1'b1; end
            B2:   begin led_nx = pat_nx[2]; pasos_nx = 4'b0100; busy_nx = 1'b1; end
            B1:   begin led_nx = pat_nx[1]; pasos_nx = 4'b0010; busy_nx = 1'b1; end
            B0:   begin led_nx = pat_nx[0]; pasos_nx = 4'b0001; busy_nx = 1'b1; end
            DONE: begin pasos_nx = 4'b1111; busy_nx = 1'b1; done_nx = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pat_q   <= 4'b0000;
            led_q   <= 1'b0;
            pasos_q <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            pat_q   <= pat_nx;
            led_q   <= led_nx;
            pasos_q <= pasos_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    assign bus.ledSecuencia = led_q;
    assign bus.ledPasos     = pasos_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_fsm_moore_tx.sv
// Directed bench for fsm_moore_tx with DEB_DIV=4, BIT_DIV=8: an edge-timing
// model is compared every cycle, plus literal spot checks per scenario.
module tb_fsm_moore_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fsm_moore_tx_if vif ();

    fsm_moore_tx #(.DEB_DIV(4), .BIT_DIV(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: n counts rising edges since the last reset edge. The button is
    // sampled every 4th edge; two consecutive high samples after not-both-high
    // put B3 on screen 3 edges later, if idle then. A run spans 40 edges.
    bit         armed = 0;
    int         n = 0;
    bit         s0 = 0, s1 = 0, both_prev = 0;
    bit         act = 0;
    int         s_start = 0;
    logic [3:0] mpat = 4'b0;
    int         pend[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1; n = 0; s0 = 0; s1 = 0; both_prev = 0; act = 0;
            pend.delete();
        end else begin
            n++;
            if (pend.size() > 0 && pend[0] == n) begin
                void'(pend.pop_front());
                if (!act) begin act = 1; s_start = n; mpat = vif.pattern; end
            end else if (act && n == s_start + 40) begin
                act = 0;
            end
            if (n % 4 == 0) begin
                s1 = s0; s0 = vif.boton;
                if (s0 && s1 && !both_prev) pend.push_back(n + 3);
                both_prev = s0 && s1;
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] exp_v, got_v;
        int m;
        if (armed) begin
            exp_v = 7'b0;
            if (act) begin
                m = (n - s_start) / 8;
                if (m < 4) exp_v = {mpat[3 - m], 4'b1000 >> m, 1'b1, 1'b0};
                else       exp_v = {1'b0, 4'b1111, 1'b1, 1'b1};
            end
            got_v = {vif.ledSecuencia, vif.ledPasos, vif.busy, vif.done};
            nvec++;
            if (got_v !== exp_v) begin
                nerr++;
                $display("FAIL model t=%0t {led,pasos,busy,done} got=%b want=%b", $time, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_busy(input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (vif.busy === 1'b1) seen = 1;
        end
        chk({name, "_start_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (vif.busy === 1'b0) seen = 1;
        end
        chk({name, "_idle_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        logic [3:0] bits;
        int width, rises, bad;
        logic prev;

        vif.boton = 1'b0;
        vif.pattern = 4'b0000;
        rst_n = 1'b0;
        idle(3);
        chk("reset_pasos", 32'(vif.ledPasos), 32'h0);
        chk("reset_busy", 32'(vif.busy), 32'h0);
        rst_n = 1'b1;

        // Quiet button: nothing should ever leave IDLE.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vif.busy || vif.done || vif.ledSecuencia || vif.ledPasos != 4'b0) bad++;
        end
        chk("quiet_idle", 32'(bad), 32'd0);

        // Clean press held well past one run: one sequence, no re-trigger.
        vif.pattern = 4'b1011;
        vif.boton = 1'b1;
        wait_busy("clean");
        chk("clean_b3_led", 32'(vif.ledSecuencia), 32'd1);
        chk("clean_b3_pasos", 32'(vif.ledPasos), 32'h8);
        idle(8);
        chk("clean_b2_led", 32'(vif.ledSecuencia), 32'd0);
        chk("clean_b2_pasos", 32'(vif.ledPasos), 32'h4);
        idle(8);
        chk("clean_b1_led", 32'(vif.ledSecuencia), 32'd1);
        chk("clean_b1_pasos", 32'(vif.ledPasos), 32'h2);
        idle(8);
        chk("clean_b0_led", 32'(vif.ledSecuencia), 32'd1);
        chk("clean_b0_pasos", 32'(vif.ledPasos), 32'h1);
        idle(8);
        chk("clean_done", 32'({vif.done, vif.ledPasos}), 32'h1F);
        idle(7);
        chk("clean_done_last", 32'(vif.done), 32'd1);
        idle(1);
        chk("clean_back_idle", 32'({vif.busy, vif.done, vif.ledPasos}), 32'h0);
        rises = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (vif.busy) rises++;
        end
        chk("hold_no_retrigger", 32'(rises), 32'd0);
        vif.boton = 1'b0;
        idle(20);

        // Bouncing press: exactly one transmission.
        vif.pattern = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            vif.boton = (i % 2 == 0);
            @(negedge clk);
        end
        vif.boton = 1'b1;
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (vif.busy && !prev) rises++;
            prev = vif.busy;
        end
        chk("bounce_one_run", 32'(rises), 32'd1);
        vif.boton = 1'b0;
        idle(30);

        // Second press with a new pattern during the run is ignored.
        vif.pattern = 4'b1011;
        vif.boton = 1'b1;
        wait_busy("repress");
        idle(2);
        vif.boton = 1'b0;
        idle(4);
        vif.pattern = 4'b0110;
        vif.boton = 1'b1;
        idle(2);
        chk("repress_b2_led", 32'(vif.ledSecuencia), 32'd0);
        idle(8);
        chk("repress_b1_led", 32'(vif.ledSecuencia), 32'd1);
        idle(8);
        chk("repress_b0_led", 32'(vif.ledSecuencia), 32'd1);
        vif.boton = 1'b0;
        wait_idle("repress");
        idle(60);

        // Reset pulse during B1 aborts; a fresh press runs a full sequence.
        vif.pattern = 4'b1011;
        vif.boton = 1'b1;
        wait_busy("abort");
        idle(2);
        vif.boton = 1'b0;
        idle(18);
        chk("abort_in_b1", 32'(vif.ledPasos), 32'h2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("abort_idle_outs", 32'({vif.ledSecuencia, vif.ledPasos, vif.busy, vif.done}), 32'h0);
        idle(20);
        vif.boton = 1'b1;
        wait_busy("after_abort");
        chk("after_abort_b3_first", 32'(vif.ledPasos), 32'h8);
        idle(7);
        chk("after_abort_b3_last", 32'(vif.ledPasos), 32'h8);
        idle(1);
        chk("after_abort_b2", 32'(vif.ledPasos), 32'h4);
        vif.boton = 1'b0;
        wait_idle("after_abort");
        idle(20);

        // All-zeros then all-ones patterns, each a full 40-cycle run.
        for (int p = 0; p < 2; p++) begin
            vif.pattern = (p == 0) ? 4'b0000 : 4'b1111;
            vif.boton = 1'b1;
            wait_busy("pat_run");
            bits = 4'b0; width = 0;
            for (int i = 0; i < 60 && vif.busy; i++) begin
                if (width % 8 == 0 && width < 32) bits[3 - width / 8] = vif.ledSecuencia;
                if (width == 2) vif.boton = 1'b0;
                width++;
                @(negedge clk);
            end
            chk(p == 0 ? "pat0000_bits" : "pat1111_bits", 32'(bits), p == 0 ? 32'h0 : 32'hF);
            chk(p == 0 ? "pat0000_width" : "pat1111_width", 32'(width), 32'd40);
            idle(20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
